qoi_decoder: RTL and testbench



---
 rtl/qoi_types_pkg.sv | 41 ++++
 rtl/qoi_index_table.sv | 28 ++
 rtl/qoi_decoder.sv | 196 +++++++++++++++++++
 tb/tb_qoi_decoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/qoi_types_pkg.sv
// Shared QOI types: pixel format, op codes, index hash and decoder state encoding.
package qoi_types;

  typedef logic [7:0]  byte_t;
  typedef logic [2:0]  addr_t;
  typedef logic [23:0] size_t;

  typedef struct packed {
    byte_t r;
    byte_t g;
    byte_t b;
    byte_t a;
  } pixel_t;

  localparam byte_t QOI_OP_RGB  = 8'hFE;
  localparam byte_t QOI_OP_RGBA = 8'hFF;

  localparam logic [1:0] QOI_TAG_INDEX = 2'b00;
  localparam logic [1:0] QOI_TAG_DIFF  = 2'b01;
  localparam logic [1:0] QOI_TAG_LUMA  = 2'b10;
  localparam logic [1:0] QOI_TAG_RUN   = 2'b11;

  localparam pixel_t QOI_PX_INIT = '{r: 8'h00, g: 8'h00, b: 8'h00, a: 8'hFF};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPCODE,
    ST_ARGS,
    ST_EMIT,
    ST_RUN,
    ST_DONE
  } dec_state_t;

  // 8-bit wrap before taking the low six bits is exact for mod 64.
  function automatic logic [5:0] qoi_hash(input pixel_t p);
    byte_t h;
    h = p.r * 8'd3 + p.g * 8'd5 + p.b * 8'd7 + p.a * 8'd11;
    return h[5:0];
  endfunction

endpackage

// File: rtl/qoi_index_table.sv
// QOI running index: register array, one write port, combinational read, sync clear-all.
module qoi_index_table
  import qoi_types::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  pixel_t                   wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output pixel_t                   rdata_o
);

  pixel_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/qoi_decoder.sv
// Memory-mapped QOI decompressor: bytes in at addr 0, one pixel out per ACK.
// Optional sticky error flag in STATUS bit4 when QOI_DEC_ERR_EN is defined.
module qoi_decoder
  import qoi_types::*;
#(
  parameter int IDX_DEPTH = 64,
  parameter int SIZE_W    = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cs,
  input  logic       we,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  input  logic [2:0] addr
);

  dec_state_t        state_q, state_d;
  pixel_t            px_q, px_d, prev_q, prev_d, idx_rdata;
  logic [SIZE_W-1:0] count_q, count_d, size_q, size_d, cnt_inc;
  logic [2:0]        need_q, need_d;
  logic [6:0]        run_q, run_d;
  byte_t             op_q, op_d;
  logic [31:0]       arg_q, arg_d, arg_w;
  byte_t             dg, dr, db;
  logic              wr, din_wr, start, ack, px_valid, in_ready, done, err;
  logic              idx_clr, idx_we;

  assign wr       = cs && we;
  assign din_wr   = wr && (addr == 3'd0);
  assign start    = wr && (addr == 3'd7) && data_i[7];
  assign ack      = wr && (addr == 3'd7) && data_i[6];
  assign px_valid = (state_q == ST_EMIT) || (state_q == ST_RUN);
  assign in_ready = (state_q == ST_OPCODE) || (state_q == ST_ARGS);
  assign done     = (state_q == ST_DONE);
  assign cnt_inc  = count_q + 1'b1;
  assign arg_w    = {arg_q[23:0], data_i};

  assign dg = {2'b00, op_q[5:0]} - 8'd32;
  assign dr = dg + {4'b0000, data_i[7:4]} - 8'd8;
  assign db = dg + {4'b0000, data_i[3:0]} - 8'd8;

  qoi_index_table #(.DEPTH(IDX_DEPTH)) u_index (
    .clk     (clk),
    .clr_i   (idx_clr),
    .we_i    (idx_we),
    .waddr_i (qoi_hash(px_q)),
    .wdata_i (px_q),
    .raddr_i (data_i[5:0]),
    .rdata_o (idx_rdata)
  );

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    prev_d  = prev_q;
    count_d = count_q;
    size_d  = size_q;
    need_d  = need_q;
    run_d   = run_q;
    op_d    = op_q;
    arg_d   = arg_q;
    idx_clr = rst;
    idx_we  = 1'b0;
    if (wr && addr == 3'd4) size_d[7:0]   = data_i;
    if (wr && addr == 3'd5) size_d[15:8]  = data_i;
    if (wr && addr == 3'd6) size_d[23:16] = data_i;
    if (start) begin
      prev_d  = QOI_PX_INIT;
      count_d = '0;
      run_d   = '0;
      need_d  = '0;
      idx_clr = 1'b1;
      state_d = (size_q == '0) ? ST_DONE : ST_OPCODE;
    end else begin
      case (state_q)
        ST_OPCODE: if (din_wr) begin
          op_d = data_i;
          if (data_i == QOI_OP_RGB) begin
            need_d  = 3'd3;
            state_d = ST_ARGS;
          end else if (data_i == QOI_OP_RGBA) begin
            need_d  = 3'd4;
            state_d = ST_ARGS;
          end else begin
            case (data_i[7:6])
              QOI_TAG_INDEX: begin
                px_d    = idx_rdata;
                state_d = ST_EMIT;
              end
              QOI_TAG_DIFF: begin
                px_d.r  = prev_q.r + {6'd0, data_i[5:4]} - 8'd2;
                px_d.g  = prev_q.g + {6'd0, data_i[3:2]} - 8'd2;
                px_d.b  = prev_q.b + {6'd0, data_i[1:0]} - 8'd2;
                px_d.a  = prev_q.a;
                state_d = ST_EMIT;
              end
              QOI_TAG_LUMA: begin
                need_d  = 3'd1;
                state_d = ST_ARGS;
              end
              default: begin
                run_d   = {1'b0, data_i[5:0]} + 7'd1;
                px_d    = prev_q;
                state_d = ST_RUN;
              end
            endcase
          end
        end
        ST_ARGS: if (din_wr) begin
          arg_d  = arg_w;
          need_d = need_q - 3'd1;
          if (need_q == 3'd1) begin
            state_d = ST_EMIT;
            if (op_q == QOI_OP_RGBA)     px_d = arg_w;
            else if (op_q == QOI_OP_RGB) px_d = {arg_w[23:0], prev_q.a};
            else px_d = '{r: prev_q.r + dr, g: prev_q.g + dg, b: prev_q.b + db, a: prev_q.a};
          end
        end
        ST_EMIT: if (ack) begin
          prev_d  = px_q;
          idx_we  = 1'b1;
          count_d = cnt_inc;
          state_d = (cnt_inc >= size_q) ? ST_DONE : ST_OPCODE;
        end
        ST_RUN: if (ack) begin
          prev_d  = px_q;
          idx_we  = 1'b1;
          count_d = cnt_inc;
          run_d   = run_q - 7'd1;
          // Size limit takes precedence over any remaining run length.
          if (cnt_inc >= size_q)      state_d = ST_DONE;
          else if (run_q == 7'd1)     state_d = ST_OPCODE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      px_q    <= QOI_PX_INIT;
      prev_q  <= QOI_PX_INIT;
      count_q <= '0;
      size_q  <= '0;
      need_q  <= '0;
      run_q   <= '0;
      op_q    <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      prev_q  <= prev_d;
      count_q <= count_d;
      size_q  <= size_d;
      need_q  <= need_d;
      run_q   <= run_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
    end
  end

`ifdef QOI_DEC_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (start) err_d = 1'b0;
    else if ((din_wr && !in_ready) || (ack && !px_valid)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    case (addr)
      3'd0:    data_o = px_q.r;
      3'd1:    data_o = px_q.g;
      3'd2:    data_o = px_q.b;
      3'd3:    data_o = px_q.a;
      3'd4:    data_o = count_q[7:0];
      3'd5:    data_o = count_q[15:8];
      3'd6:    data_o = count_q[23:16];
      default: data_o = {px_valid, in_ready, done, err, 4'b0000};
    endcase
  end

endmodule

// File: tb/tb_qoi_decoder.sv
// Directed bench for qoi_decoder: bus writes on the falling edge, reads between edges.
module tb_qoi_decoder;

  logic       clk = 1'b0;
  logic       rst, cs, we;
  logic [7:0] data_i, data_o;
  logic [2:0] addr;
  int         n_tests = 0;
  int         n_fail  = 0;

`ifdef QOI_DEC_ERR_EN
  localparam logic [7:0] ERRB = 8'h10;
`else
  localparam logic [7:0] ERRB = 8'h00;
`endif

  qoi_decoder dut (
    .clk    (clk),
    .rst    (rst),
    .cs     (cs),
    .we     (we),
    .data_i (data_i),
    .data_o (data_o),
    .addr   (addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; addr = a; data_i = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [7:0] d);
    addr = a;
    #1;
    d = data_o;
  endtask

  task automatic rd_px(output logic [31:0] p);
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      bus_rd(3'(i), b);
      p = {p[23:0], b};
    end
  endtask

  task automatic rd_cnt(output logic [31:0] c);
    logic [7:0] b0, b1, b2;
    bus_rd(3'd4, b0);
    bus_rd(3'd5, b1);
    bus_rd(3'd6, b2);
    c = {8'h00, b2, b1, b0};
  endtask

  task automatic chk_status(input string tag, input logic [7:0] exp);
    logic [7:0] s;
    bus_rd(3'd7, s);
    check(tag, {24'd0, s}, {24'd0, exp});
  endtask

  task automatic chk_px(input string tag, input logic [31:0] exp);
    logic [31:0] p;
    rd_px(p);
    check(tag, p, exp);
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    logic [31:0] c;
    rd_cnt(c);
    check(tag, c, exp);
  endtask

  task automatic start(); bus_wr(3'd7, 8'h80); endtask
  task automatic ack();   bus_wr(3'd7, 8'h40); endtask
  task automatic push(input logic [7:0] d); bus_wr(3'd0, d); endtask

  initial begin
    rst = 1'b1; cs = 1'b0; we = 1'b0; data_i = '0; addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_status("rst_status", 8'h00);
    chk_cnt("rst_count", 32'd0);
    chk_px("rst_pixel", 32'h000000FF);

    // RGB op then ACK
    bus_wr(3'd4, 8'd100);
    start();
    chk_status("start_ready", 8'h40);
    push(8'hFE); push(8'h10); push(8'h20);
    chk_status("rgb_partial", 8'h40);
    push(8'h30);
    chk_status("rgb_valid", 8'h80);
    chk_px("rgb_pixel", 32'h102030FF);
    ack();
    chk_cnt("rgb_count", 32'd1);
    chk_status("rgb_after_ack", 8'h40);

    // INDEX hit on hash 21, then DIFF +1
    push(8'h15);
    chk_px("index_pixel", 32'h102030FF);
    ack();
    push(8'h7F);
    chk_px("diff_pixel", 32'h112131FF);
    ack();
    chk_cnt("diff_count", 32'd3);

    // LUMA dg=+2 dr=+3 db=+4
    push(8'hA2);
    chk_status("luma_args", 8'h40);
    push(8'h9A);
    chk_px("luma_pixel", 32'h142335FF);
    ack();

    // DIFF wraparound from the default pixel
    start();
    chk_cnt("restart_count", 32'd0);
    push(8'h40);
    chk_px("diff_wrap", 32'hFEFEFEFF);
    ack();
    chk_cnt("wrap_count", 32'd1);

    // Run truncated by SIZE=3
    bus_wr(3'd4, 8'd3);
    start();
    push(8'hFE); push(8'h01); push(8'h02); push(8'h03);
    chk_px("run_seed", 32'h010203FF);
    ack();
    push(8'hC2);
    chk_status("run_valid", 8'h80);
    chk_px("run_pixel", 32'h010203FF);
    ack();
    chk_status("run_mid", 8'h80);
    chk_cnt("run_mid_count", 32'd2);
    ack();
    chk_status("run_done", 8'h20);
    chk_cnt("run_done_count", 32'd3);
    ack();
    chk_cnt("spurious_ack_count", 32'd3);
    chk_status("spurious_ack_err", 8'h20 | ERRB);
    push(8'h55);
    chk_status("done_drop", 8'h20 | ERRB);

    // SIZE=0 goes straight to DONE and START clears err
    bus_wr(3'd4, 8'd0);
    start();
    chk_status("size0_done", 8'h20);

    // START mid-ARGS clears index and count
    bus_wr(3'd4, 8'd100);
    start();
    push(8'hFE); push(8'h10); push(8'h20); push(8'h30);
    ack();
    push(8'hFF); push(8'h01);
    start();
    chk_status("midargs_status", 8'h40);
    chk_cnt("midargs_count", 32'd0);
    push(8'h15);
    chk_px("index_cleared", 32'h00000000);
    push(8'h00);
    chk_status("emit_din_err", 8'h80 | ERRB);
    start();
    chk_status("start_clears_err", 8'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
